mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
// - Load/store initiator between the CPU memory stage and the word-only data memory (32-bit words,
//   combinational read, write on posedge clk when we=1, word index = address[31:2]).
// - Accepts byte/halfword/word loads and stores over a valid/ready handshake.
// - Performs read-modify-write for sub-word stores and sign/zero extension for sub-word loads.
// - Flags misaligned or out-of-range accesses as faults; a faulted access never touches memory.
// PARAMETERS
// - DEPTH   64   data memory size in words; legal word index is 0..DEPTH-1
// PORTS
// - clk          in   1   single clock, all state on posedge
// - rst_n        in   1   reset, asynchronous, active-low
// - req_valid    in   1   request present
// - req_ready    out  1   unit can accept; 1 only in IDLE
// - req_write    in   1   1=store, 0=load
// - req_size     in   2   00=byte, 01=half, 10=word, 11=illegal (fault)
// - req_signed   in   1   loads: 1=sign-extend, 0=zero-extend; ignored for stores/word
// - req_addr     in   32  byte address
// - req_wdata    in   32  store data; byte in [7:0], half in [15:0]
// - resp_valid   out  1   response held until resp_ready
// - resp_ready   in   1   consumer accepts response
// - resp_rdata   out  32  load result (0 for stores and faults)
// - resp_fault   out  1   misaligned / out-of-range / illegal size
// - mem_we       out  1   memory write enable
// - mem_a        out  32  memory byte address, always word aligned ([1:0]=00)
// - mem_wd       out  32  memory write data
// - mem_rd       in   32  memory read data (combinational from mem_a)
// BEHAVIOUR
// - Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_we=0, mem_a=0,
//   mem_wd=0. Outputs are registered, so mem_we drops asynchronously when rst_n falls.
// - Accept on req_valid & req_ready at edge T: latch all request fields.
// - Fault check at accept: half with addr[0]=1, word with addr[1:0]!=0, size=11, or
//   addr[31:2]>=DEPTH. Fault -> RESP at T+1 with resp_fault=1, resp_rdata=0, mem_we never asserted.
// - States: IDLE, LOAD, RMW_RD, WRITE, RESP.
// - Load: IDLE->LOAD. In LOAD, mem_a=word address; at edge T+1, extract lane (byte lane=addr[1:0],
//   half lane=addr[1]), extend per req_signed, latch into resp_rdata. RESP from T+1.
// - Word store: IDLE->WRITE. In WRITE, mem_we=1, mem_wd=req_wdata; the memory commits at edge T+1.
//   RESP from T+1.
// - Sub-word store: IDLE->RMW_RD (sample mem_rd at T+1) -> WRITE (merged word: only the addressed
//   lane replaced; memory commits at T+2) -> RESP from T+2.
// - mem_we=1 only in WRITE, for exactly one cycle per store.
// - RESP: resp_valid=1 and fields stable until resp_ready; then ->IDLE. resp_valid & resp_ready at
//   edge E clears resp_valid and sets req_ready=1 from E. No new accept during the same cycle
//   (back-to-back issue rate is one request per response cycle + 1).
// - req_* inputs are ignored while req_ready=0.
// - Reset mid-operation returns to IDLE; an abandoned RMW is not written. A WRITE whose commit edge
//   has already occurred stays committed.
// STRUCTURE
// - Package mau_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state enum, lane extract/merge functions.
// - Sub-module lane_merge (combinational): extract plus sign/zero extend for loads; lane replace for
//   stores. The FSM and registers stay in mem_access_unit.
// TESTING
// - Word store addr 0x10, data 0xDEADBEEF, then word load 0x10 -> mem_we pulse once at word 4;
//   resp_rdata=0xDEADBEEF, resp_fault=0.
// - Memory word 4 = 0x11223344; byte store 0xAA to 0x12 -> word 4 = 0x11AA3344, mem_we high 1 cycle.
//   Signed byte load 0x12 -> 0xFFFFFFAA; unsigned byte load -> 0x000000AA.
// - Half load 0x13 -> resp_fault=1 one cycle after accept, resp_rdata=0, no mem_we.
//   Word load 0x100 (DEPTH=64) -> fault.
// - resp_ready held 0 for 5 cycles -> resp_valid and fields stable, req_ready=0.
//   Next request accepted only after the response handshake.
// - rst_n low during RMW_RD of a half store -> mem_we never asserts, target word unchanged,
//   all outputs at reset values.
// - Size=11 store -> fault, memory untouched; random load/store mix compared against a reference
//   byte-array model.

Source files
------------

// File: rtl/mau_pkg.sv
// Shared encodings and lane helpers for the load/store initiator.
// Little-endian lanes: byte lane = addr[1:0], half lane = addr[1].
package mau_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_RD,
        ST_WRITE,
        ST_RESP
    } state_e;

    function automatic logic [31:0] extract_lane(input logic [31:0] word, input size_e size,
                                                 input logic [1:0] lane, input logic sign);
        logic [31:0] sh;
        logic [31:0] res;
        sh  = word;
        res = word;
        case (size)
            SZ_BYTE: begin
                sh  = word >> {lane, 3'b000};
                res = {{24{sign & sh[7]}}, sh[7:0]};
            end
            SZ_HALF: begin
                sh  = word >> {lane[1], 4'b0000};
                res = {{16{sign & sh[15]}}, sh[15:0]};
            end
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] merge_lane(input logic [31:0] word, input size_e size,
                                               input logic [1:0] lane, input logic [31:0] wdata);
        logic [31:0] mask;
        logic [31:0] data;
        case (size)
            SZ_BYTE: begin
                mask = 32'h0000_00FF << {lane, 3'b000};
                data = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                mask = 32'h0000_FFFF << {lane[1], 4'b0000};
                data = {2{wdata[15:0]}};
            end
            default: begin
                mask = '1;
                data = wdata;
            end
        endcase
        return (word & ~mask) | (data & mask);
    endfunction

    function automatic logic is_fault(input size_e size, input logic [31:0] addr,
                                      input int unsigned depth);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr[0];
            SZ_WORD: bad = (addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad || ({2'b00, addr[31:2]} >= depth);
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_merge.sv
// Combinational lane handling: load extract/extend and store lane replace.
module lane_merge
    import mau_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    always_comb begin
        load_data = extract_lane(word, size_e'(size), lane, sign);
        merged    = merge_lane(word, size_e'(size), lane, wdata);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-only data memory: handshake, fault check,
// read-modify-write for sub-word stores, extension for sub-word loads.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    state_e      state, state_n;
    logic        wr_q, wr_n;
    size_e       sz_q, sz_n;
    logic        sg_q, sg_n;
    logic [1:0]  lane_q, lane_n;
    logic [31:0] wdata_q, wdata_n;
    logic        flt_q, flt_n;

    logic        req_ready_n;
    logic        resp_valid_n;
    logic [31:0] resp_rdata_n;
    logic        resp_fault_n;
    logic        mem_we_n;
    logic [31:0] mem_a_n;
    logic [31:0] mem_wd_n;

    logic [31:0] load_data;
    logic [31:0] merged;

    lane_merge u_lane_merge (
        .size      (sz_q),
        .sign      (sg_q),
        .lane      (lane_q),
        .word      (mem_rd),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_comb begin
        state_n      = state;
        wr_n         = wr_q;
        sz_n         = sz_q;
        sg_n         = sg_q;
        lane_n       = lane_q;
        wdata_n      = wdata_q;
        flt_n        = flt_q;
        req_ready_n  = req_ready;
        resp_valid_n = resp_valid;
        resp_rdata_n = resp_rdata;
        resp_fault_n = resp_fault;
        mem_we_n     = mem_we;
        mem_a_n      = mem_a;
        mem_wd_n     = mem_wd;

        case (state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    wr_n        = req_write;
                    sz_n        = size_e'(req_size);
                    sg_n        = req_signed;
                    lane_n      = req_addr[1:0];
                    wdata_n     = req_wdata;
                    flt_n       = is_fault(size_e'(req_size), req_addr, DEPTH);
                    req_ready_n = 1'b0;
                    // Faults reuse LOAD as a one-cycle delay slot; mem_a is left untouched.
                    if (flt_n) begin
                        state_n = ST_LOAD;
                    end else begin
                        mem_a_n = {req_addr[31:2], 2'b00};
                        if (!req_write) begin
                            state_n = ST_LOAD;
                        end else if (size_e'(req_size) == SZ_WORD) begin
                            state_n  = ST_WRITE;
                            mem_we_n = 1'b1;
                            mem_wd_n = req_wdata;
                        end else begin
                            state_n = ST_RMW_RD;
                        end
                    end
                end
            end
            ST_LOAD: begin
                resp_valid_n = 1'b1;
                resp_fault_n = flt_q;
                resp_rdata_n = flt_q ? '0 : load_data;
                state_n      = ST_RESP;
            end
            ST_RMW_RD: begin
                mem_we_n = 1'b1;
                mem_wd_n = merged;
                state_n  = ST_WRITE;
            end
            ST_WRITE: begin
                mem_we_n     = 1'b0;
                resp_valid_n = 1'b1;
                resp_fault_n = 1'b0;
                resp_rdata_n = '0;
                state_n      = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_n = 1'b0;
                    req_ready_n  = 1'b1;
                    state_n      = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            wr_q       <= 1'b0;
            sz_q       <= SZ_BYTE;
            sg_q       <= 1'b0;
            lane_q     <= '0;
            wdata_q    <= '0;
            flt_q      <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
            mem_we     <= 1'b0;
            mem_a      <= '0;
            mem_wd     <= '0;
        end else begin
            state      <= state_n;
            wr_q       <= wr_n;
            sz_q       <= sz_n;
            sg_q       <= sg_n;
            lane_q     <= lane_n;
            wdata_q    <= wdata_n;
            flt_q      <= flt_n;
            req_ready  <= req_ready_n;
            resp_valid <= resp_valid_n;
            resp_rdata <= resp_rdata_n;
            resp_fault <= resp_fault_n;
            mem_we     <= mem_we_n;
            mem_a      <= mem_a_n;
            mem_wd     <= mem_wd_n;
        end
    end

    // Latched write flag is informational only; the state already encodes the direction.
    logic unused_wr;
    assign unused_wr = wr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array reference model, directed cases and random mix.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_fault;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    logic [31:0] mem [64];
    logic [7:0]  rb  [256];
    int unsigned we_cnt = 0;
    int unsigned we_seen = 0;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        int unsigned nwr;
    } exp_t;
    exp_t expq[$];

    mem_access_unit #(.DEPTH(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[7:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_a[7:2]] <= mem_wd;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    endtask

    // Reference: little-endian byte array, outcome computed from the access rules.
    task automatic model(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic f, output logic [31:0] rd, output int lat,
                         output int unsigned nwr);
        int nb;
        f   = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00)
              || (a >= 32'd256);
        rd  = '0;
        nwr = 0;
        lat = 1;
        nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        if (!f) begin
            if (w) begin
                for (int k = 0; k < nb; k++) rb[int'(a) + k] = wd[8*k +: 8];
                nwr = 1;
                lat = (nb == 4) ? 1 : 2;
            end else begin
                for (int k = 0; k < nb; k++) rd[8*k +: 8] = rb[int'(a) + k];
                if (sg && nb == 1 && rd[7])  rd[31:8]  = '1;
                if (sg && nb == 2 && rd[15]) rd[31:16] = '1;
            end
        end
    endtask

    task automatic garbage();
        req_valid  = 1'($urandom);
        req_write  = 1'($urandom);
        req_size   = 2'($urandom);
        req_signed = 1'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input int hold,
                         output logic [31:0] got_rd, output logic got_f);
        logic        ef;
        logic [31:0] erd;
        int          lat;
        int unsigned nwr;
        int          n;
        exp_t        e;
        got_rd = '0;
        got_f  = 1'b0;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", {31'b0, req_ready}, 32'd1);
            finish_run();
        end
        model(w, sz, sg, a, wd, ef, erd, lat, nwr);
        e.fault = ef;
        e.rdata = erd;
        e.nwr   = nwr;
        expq.push_back(e);
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!resp_valid) garbage();
        end while (!resp_valid && n < 10);
        if (!resp_valid) begin
            check("resp_timeout", {31'b0, resp_valid}, 32'd1);
            finish_run();
        end
        check("resp_latency", 32'(n), 32'(lat + 1));
        got_rd = resp_rdata;
        got_f  = resp_fault;
        for (int k = 0; k < hold; k++) begin
            garbage();
            @(negedge clk);
            check("hold_valid", {31'b0, resp_valid}, 32'd1);
            check("hold_rdata", resp_rdata, got_rd);
            check("hold_fault", {31'b0, resp_fault}, {31'b0, got_f});
            check("hold_req_ready", {31'b0, req_ready}, 32'd0);
        end
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check("post_hs_valid", {31'b0, resp_valid}, 32'd0);
        check("post_hs_ready", {31'b0, req_ready}, 32'd1);
    endtask

    // Compare process: alignment every cycle, response contents at each handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            check("mem_a_align", {30'b0, mem_a[1:0]}, 32'd0);
            if (resp_valid && resp_ready) begin
                if (expq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got response, expected none at %0t", $time);
                end else begin
                    e = expq.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_fault", {31'b0, resp_fault}, {31'b0, e.fault});
                    check("mem_we_count", we_cnt - we_seen, e.nwr);
                    we_seen = we_cnt;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  {31'b0, req_ready},  32'd1);
        check({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
        check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
        check({tag, "_resp_fault"}, {31'b0, resp_fault}, 32'd0);
        check({tag, "_mem_we"},     {31'b0, mem_we},     32'd0);
        check({tag, "_mem_a"},      mem_a,  32'd0);
        check({tag, "_mem_wd"},     mem_wd, 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic        f;
        logic [31:0] snap;
        int unsigned wc;

        for (int i = 0; i < 256; i++) rb[i] = 8'($urandom);
        for (int i = 0; i < 64; i++) mem[i] = {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]};
        req_valid = 0; req_write = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0; resp_ready = 0;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, r, f);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0, r, f);
        check("word_rt_rdata", r, 32'hDEADBEEF);
        check("word_rt_fault", {31'b0, f}, 32'd0);

        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 0, r, f);
        issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA, 0, r, f);
        check("byte_store_word4", mem[4], 32'h11AA3344);
        issue(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 0, r, f);
        check("lb_signed", r, 32'hFFFFFFAA);
        issue(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 0, r, f);
        check("lb_unsigned", r, 32'h000000AA);

        issue(1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 0, r, f);
        check("half_misalign_fault", {31'b0, f}, 32'd1);
        check("half_misalign_rdata", r, 32'd0);
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, r, f);
        check("oob_fault", {31'b0, f}, 32'd1);

        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5, r, f);
        check("held_rdata", r, 32'h11AA3344);

        issue(1'b1, 2'b10, 1'b0, 32'h14, 32'hCAFEF00D, 0, r, f);
        @(negedge clk);
        check("pre_rmw_ready", {31'b0, req_ready}, 32'd1);
        req_write = 1'b1; req_size = 2'b01; req_signed = 1'b0;
        req_addr = 32'h16; req_wdata = 32'h00001234; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        wc = we_cnt;
        rst_n = 1'b0;
        #1 check_reset_outputs("mid_rmw");
        repeat (3) begin
            @(negedge clk);
            check("mid_rmw_we_low", {31'b0, mem_we}, 32'd0);
        end
        check("mid_rmw_no_write", we_cnt, wc);
        check("mid_rmw_word5", mem[5], 32'hCAFEF00D);
        rst_n = 1'b1;
        @(negedge clk);

        snap = mem[8];
        issue(1'b1, 2'b11, 1'b0, 32'h20, 32'h55555555, 0, r, f);
        check("bad_size_fault", {31'b0, f}, 32'd1);
        check("bad_size_untouched", mem[8], snap);

        for (int i = 0; i < 200; i++) begin
            issue(1'($urandom), 2'($urandom), 1'($urandom), 32'($urandom_range(0, 271)),
                  $urandom, int'($urandom_range(0, 3)), r, f);
        end

        for (int i = 0; i < 64; i++) begin
            check($sformatf("final_word_%0d", i), mem[i],
                  {rb[4*i+3], rb[4*i+2], rb[4*i+1], rb[4*i]});
        end
        check("queue_drained", expq.size(), 32'd0);
        finish_run();
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected finish");
        n_bad++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "timeout");
    end

endmodule
